// File: rtl/shot_scheduler.sv
// Shot magazine sequencer: launches slots in order with a frame-based cooldown,
// tracks in-flight slots and runs a timed reload once the magazine is spent and retired.
module shot_scheduler #(
    parameter int NUM_SHOTS       = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int RELOAD_FRAMES   = 32
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 fireReq,
    input  logic [NUM_SHOTS-1:0] shotDone,
    output logic [NUM_SHOTS-1:0] shootEnable,
    output logic [NUM_SHOTS-1:0] busy,
    output logic [3:0]           ammoLeft,
    output logic                 reloading,
    output logic                 SHP_reload
);

    // One counter serves both cooldown and reload; sized for the larger of the two.
    localparam int CNT_MAX = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] RELOAD_LOAD = CNT_W'(RELOAD_FRAMES);
    localparam logic [3:0]       AMMO_FULL   = 4'(NUM_SHOTS);
    localparam logic [NUM_SHOTS-1:0] NO_SLOTS = {NUM_SHOTS{1'b0}};

    typedef enum logic [1:0] {
        READY    = 2'd0,
        COOLDOWN = 2'd1,
        EMPTY    = 2'd2,
        RELOAD   = 2'd3
    } state_t;

    state_t               state_r;
    logic [3:0]           idx_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [NUM_SHOTS-1:0] slot_mask_s;
    logic [NUM_SHOTS-1:0] launch_mask_s;
    logic [NUM_SHOTS-1:0] busy_next_s;
    logic                 fire_ok_s;

    function automatic logic [NUM_SHOTS-1:0] slot_onehot(input logic [3:0] slot);
        logic [NUM_SHOTS-1:0] oh;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            oh[i] = (slot == 4'(i));
        end
        return oh;
    endfunction

    // Fire acceptance and next in-flight vector; a launch overrides a same-cycle done.
    always_comb begin
        slot_mask_s = slot_onehot(idx_r);
        if ((state_r == READY) && fireReq && (ammoLeft != 4'd0) &&
            ((busy & slot_mask_s) == NO_SLOTS)) begin
            fire_ok_s = 1'b1;
        end else begin
            fire_ok_s = 1'b0;
        end
        if (fire_ok_s) begin
            launch_mask_s = slot_mask_s;
        end else begin
            launch_mask_s = NO_SLOTS;
        end
        busy_next_s = (busy & ~shotDone) | launch_mask_s;
    end

    // Magazine state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r     <= READY;
            idx_r       <= 4'd0;
            cnt_r       <= CNT_ZERO;
            shootEnable <= NO_SLOTS;
            busy        <= NO_SLOTS;
            ammoLeft    <= AMMO_FULL;
            reloading   <= 1'b0;
            SHP_reload  <= 1'b0;
        end else begin
            shootEnable <= launch_mask_s;
            busy        <= busy_next_s;
            SHP_reload  <= 1'b0;
            case (state_r)
                READY: begin
                    if (fire_ok_s) begin
                        ammoLeft <= ammoLeft - 4'd1;
                        idx_r    <= idx_r + 4'd1;
                        cnt_r    <= COOL_LOAD;
                        if (ammoLeft == 4'd1) begin
                            state_r   <= EMPTY;
                            reloading <= 1'b1;
                        end else begin
                            state_r   <= COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= READY;
                    end else if (startOfFrame) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                EMPTY: begin
                    reloading <= 1'b1;
                    // Reload only starts once every launched shot has retired.
                    if (busy == NO_SLOTS) begin
                        cnt_r   <= RELOAD_LOAD;
                        state_r <= RELOAD;
                    end
                end
                RELOAD: begin
                    reloading <= 1'b1;
                    if (startOfFrame) begin
                        if (cnt_r <= CNT_ONE) begin
                            cnt_r      <= CNT_ZERO;
                            SHP_reload <= 1'b1;
                            ammoLeft   <= AMMO_FULL;
                            idx_r      <= 4'd0;
                            reloading  <= 1'b0;
                            state_r    <= READY;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: fixed vector table, directed magazine/reload sequences,
// then random traffic against a slot/ammo/timer reference model.
module tb_shot_scheduler;

    localparam int NS = 8;
    localparam int CD = 4;
    localparam int RL = 32;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          fireReq = 1'b0;
    logic [NS-1:0] shotDone = '0;
    logic [NS-1:0] shootEnable;
    logic [NS-1:0] busy;
    logic [3:0]    ammoLeft;
    logic          reloading;
    logic          SHP_reload;

    int n_checks = 0;
    int n_fail   = 0;

    shot_scheduler #(.NUM_SHOTS(NS), .COOLDOWN_FRAMES(CD), .RELOAD_FRAMES(RL)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
        .shotDone(shotDone), .shootEnable(shootEnable), .busy(busy), .ammoLeft(ammoLeft),
        .reloading(reloading), .SHP_reload(SHP_reload)
    );

    always #5 clk = ~clk;

    // Reference model: magazine contents, next slot, and remaining frame timers.
    int          m_ammo, m_slot;
    int          m_cool;     // frames left in cooldown, -1 when not cooling down
    int          m_reload;   // frames left in reload, -1 when not reloading
    bit          m_wait;     // magazine spent, waiting for slots to retire
    logic [NS-1:0] m_busy, m_se;
    bit          m_shp;

    task automatic model_reset();
        m_ammo = NS; m_slot = 0; m_cool = -1; m_reload = -1; m_wait = 0;
        m_busy = '0; m_se = '0; m_shp = 0;
    endtask

    task automatic model_edge(input bit f, input bit s, input logic [NS-1:0] d, input bit r);
        logic [NS-1:0] slot_bit;
        if (!r) begin
            model_reset();
            return;
        end
        m_se = '0; m_shp = 0;
        if (m_cool < 0 && !m_wait && m_reload < 0) begin
            slot_bit = NS'(1) << m_slot;
            if (f && m_ammo > 0 && (m_busy & slot_bit) == '0) begin
                m_se = slot_bit;
                m_ammo--; m_slot++;
                if (m_ammo == 0) m_wait = 1;
                else m_cool = CD;
            end
        end else if (m_cool >= 0) begin
            if (m_cool == 0) m_cool = -1;
            else if (s) m_cool--;
        end else if (m_wait) begin
            if (m_busy == '0) begin
                m_wait = 0; m_reload = RL;
            end
        end else begin
            if (s) begin
                if (m_reload == 1) begin
                    m_reload = -1; m_shp = 1; m_ammo = NS; m_slot = 0;
                end else begin
                    m_reload--;
                end
            end
        end
        m_busy = (m_busy & ~d) | m_se;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit f, input bit s, input logic [NS-1:0] d, input bit r);
        fireReq = f; startOfFrame = s; shotDone = d; resetN = r;
        @(posedge clk);
        model_edge(f, s, d, r);
        #1;
        chk("model_shootEnable", 32'(shootEnable), 32'(m_se));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_ammoLeft", 32'(ammoLeft), 32'(m_ammo));
        chk("model_reloading", 32'(reloading), 32'(m_wait || m_reload >= 0));
        chk("model_SHP_reload", 32'(SHP_reload), 32'(m_shp));
    endtask

    // One launch followed by enough frames for the cooldown to expire.
    task automatic fire_and_cool(input int k);
        step(1, 0, '0, 1);
        chk("seq_launch_onehot", 32'(shootEnable), 32'(8'h01) << k);
        chk("seq_launch_ammo", 32'(ammoLeft), 32'(7 - k));
        for (int j = 0; j < CD; j++) step(0, 1, '0, 1);
        step(0, 0, '0, 1);
    endtask

    typedef struct {
        bit            f;
        bit            s;
        logic [NS-1:0] d;
        bit            r;
        logic [NS-1:0] se;
        logic [NS-1:0] bz;
        logic [3:0]    ammo;
        bit            rl;
        bit            shp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        model_reset();
        //            f  s  done   rst  se     busy   ammo rl shp
        tbl[0]  = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 4'd8, 0, 0};
        tbl[1]  = '{0, 0, 8'h00, 1, 8'h00, 8'h00, 4'd8, 0, 0};
        tbl[2]  = '{1, 0, 8'h00, 1, 8'h01, 8'h01, 4'd7, 0, 0};
        tbl[3]  = '{1, 0, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[4]  = '{0, 1, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[5]  = '{0, 1, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[6]  = '{0, 1, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[7]  = '{1, 1, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[8]  = '{1, 0, 8'h00, 1, 8'h00, 8'h01, 4'd7, 0, 0};
        tbl[9]  = '{1, 0, 8'h00, 1, 8'h02, 8'h03, 4'd6, 0, 0};
        tbl[10] = '{0, 0, 8'h01, 1, 8'h00, 8'h02, 4'd6, 0, 0};
        tbl[11] = '{0, 0, 8'h10, 1, 8'h00, 8'h02, 4'd6, 0, 0};
        tbl[12] = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 4'd8, 0, 0};
        tbl[13] = '{1, 0, 8'h00, 1, 8'h01, 8'h01, 4'd7, 0, 0};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].f, tbl[i].s, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_shootEnable", i), 32'(shootEnable), 32'(tbl[i].se));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("tbl%0d_ammoLeft", i), 32'(ammoLeft), 32'(tbl[i].ammo));
            chk($sformatf("tbl%0d_reloading", i), 32'(reloading), 32'(tbl[i].rl));
            chk($sformatf("tbl%0d_SHP_reload", i), 32'(SHP_reload), 32'(tbl[i].shp));
        end

        // Spend the whole magazine, hold two slots in flight, then reload.
        step(0, 0, '0, 0);
        for (int k = 0; k < NS; k++) fire_and_cool(k);
        chk("empty_ammo", 32'(ammoLeft), 32'd0);
        chk("empty_reloading", 32'(reloading), 32'd1);
        step(1, 0, '0, 1);
        chk("empty_fire_dropped", 32'(shootEnable), 32'd0);
        step(0, 0, 8'h7E, 1);
        chk("empty_busy81", 32'(busy), 32'h81);
        for (int j = 0; j < 40; j++) step(0, 1, '0, 1);
        chk("empty_stall_reloading", 32'(reloading), 32'd1);
        chk("empty_stall_ammo", 32'(ammoLeft), 32'd0);
        step(0, 0, 8'h01, 1);
        step(0, 0, 8'h80, 1);
        chk("retired_busy", 32'(busy), 32'd0);
        step(0, 0, '0, 1);
        for (int j = 0; j < RL - 1; j++) begin
            step(0, 1, '0, 1);
            chk("reload_early_shp", 32'(SHP_reload), 32'd0);
        end
        step(1, 1, '0, 1);
        chk("reload_shp", 32'(SHP_reload), 32'd1);
        chk("reload_ammo", 32'(ammoLeft), 32'd8);
        chk("reload_reloading", 32'(reloading), 32'd0);
        chk("reload_fire_ignored", 32'(shootEnable), 32'd0);
        step(0, 0, '0, 1);
        chk("reload_shp_one_cycle", 32'(SHP_reload), 32'd0);
        step(1, 0, '0, 1);
        chk("reload_next_slot0", 32'(shootEnable), 32'h01);

        // Reset in the middle of a reload.
        step(0, 0, '0, 0);
        for (int k = 0; k < NS; k++) fire_and_cool(k);
        step(0, 0, 8'hFF, 1);
        step(0, 0, '0, 1);
        for (int j = 0; j < RL - 10; j++) step(0, 1, '0, 1);
        step(0, 1, '0, 0);
        chk("midreset_ammo", 32'(ammoLeft), 32'd8);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_reloading", 32'(reloading), 32'd0);
        chk("midreset_shp", 32'(SHP_reload), 32'd0);
        for (int j = 0; j < 12; j++) step(0, 1, '0, 1);
        step(1, 0, '0, 1);
        chk("midreset_fire_slot0", 32'(shootEnable), 32'h01);

        // Random traffic against the model.
        step(0, 0, '0, 0);
        for (int c = 0; c < 4000; c++) begin
            bit f, s, r;
            logic [NS-1:0] d;
            f = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0) ? (m_busy & NS'($urandom)) : '0;
            if ($urandom_range(0, 30) == 0) d = d | NS'($urandom);
            r = ($urandom_range(0, 499) != 0);
            step(f, s, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
